// File: rtl/paddle_ctrl.sv
// Paddle position controller for the pong playfield.
// Keeps the paddle as a registered left-edge position, steps it from a
// quadrature encoder count, with optional acceleration on fast spins, or from
// a CPU target column in auto mode. The occupancy mask is derived from the
// position and the currently selected paddle width.
module paddle_ctrl #(
  parameter int FIELD_W      = 16,
  parameter int PW0          = 8,
  parameter int PW1          = 6,
  parameter int PW2          = 4,
  parameter int PW3          = 3,
  parameter int STEP_FAST    = 2,
  parameter int ACCEL_WINDOW = 1000,
  parameter int AUTO_DIV     = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 width,
  input  logic [1:0]                 encoder_value,
  input  logic                       auto_mode,
  input  logic [$clog2(FIELD_W)-1:0] target_col,
  output logic [FIELD_W-1:0]         paddle_o,
  output logic [$clog2(FIELD_W)-1:0] pos_o,
  output logic                       at_min,
  output logic                       at_max,
  output logic                       moved
);

  localparam int PW = $clog2(FIELD_W);
  localparam int WW = $clog2(FIELD_W + 1);
  // Signed width for position arithmetic: holds pos + STEP_FAST and
  // pos - STEP_FAST without wrapping.
  localparam int CW = $clog2(FIELD_W + STEP_FAST + 1) + 2;
  localparam int RW = $clog2(ACCEL_WINDOW + 1);
  localparam int AW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;

  localparam logic [PW-1:0] POS_RESET  = PW'((FIELD_W - PW0) / 2);
  localparam logic [RW-1:0] RUN_SAT    = RW'(ACCEL_WINDOW);
  localparam logic [AW-1:0] AUTO_LAST  = AW'(AUTO_DIV - 1);

  // LEFT moves toward column 0, RIGHT toward column FIELD_W-1.
  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_e;

  logic [PW-1:0] pos_q, pos_d;
  logic [1:0]    prev_q;
  logic          primed_q;
  dir_e          last_dir_q, last_dir_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic [AW-1:0] auto_cnt_q, auto_cnt_d;
  logic          moved_q, moved_d;

  logic [WW-1:0]        w;
  logic [1:0]           diff;
  dir_e                 enc_dir;
  dir_e                 step_dir;
  logic                 fast;
  logic signed [CW-1:0] pos_s, lim_s, centre_s, target_s, step_s, cand_s, clamp_s;

  // Decode the selected paddle width.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path (default
    // first), otherwise synthesis infers a latch to hold the old value.
    w = WW'(PW0);
    case (width)
      2'd1:    w = WW'(PW1);
      2'd2:    w = WW'(PW2);
      2'd3:    w = WW'(PW3);
      default: w = WW'(PW0);
    endcase
  end

  assign pos_s    = $signed(CW'(pos_q));
  assign lim_s    = $signed(CW'(FIELD_W)) - $signed(CW'(w));
  assign centre_s = pos_s + $signed(CW'(w >> 1));
  assign target_s = $signed(CW'(target_col));

  // Encoder/auto step decision, acceleration bookkeeping and clamped next position.
  always_comb begin
    diff       = encoder_value - prev_q;
    enc_dir    = DIR_NONE;
    step_dir   = DIR_NONE;
    fast       = 1'b0;
    last_dir_d = last_dir_q;
    run_cnt_d  = run_cnt_q;
    auto_cnt_d = auto_cnt_q;

    // +1 is a step toward column 0, -1 toward the far wall; 0 and the
    // ambiguous half-turn (2'b10) produce no step.
    if (diff == 2'b01) begin
      enc_dir = DIR_LEFT;
    end else if (diff == 2'b11) begin
      enc_dir = DIR_RIGHT;
    end

    if (!auto_mode) begin
      auto_cnt_d = '0;
    end

    // The first cycle after reset only captures the encoder count.
    if (primed_q) begin
      if (auto_mode) begin
        if (auto_cnt_q == AUTO_LAST) begin
          auto_cnt_d = '0;
          if (target_s < centre_s) begin
            step_dir = DIR_LEFT;
          end else if (target_s > centre_s) begin
            step_dir = DIR_RIGHT;
          end
        end else begin
          auto_cnt_d = auto_cnt_q + AW'(1);
        end
      end else if (enc_dir != DIR_NONE) begin
        step_dir   = enc_dir;
        fast       = (enc_dir == last_dir_q) && (run_cnt_q < RUN_SAT);
        last_dir_d = enc_dir;
        run_cnt_d  = '0;
      end else if (run_cnt_q < RUN_SAT) begin
        run_cnt_d = run_cnt_q + RW'(1);
      end
    end

    step_s = fast ? $signed(CW'(STEP_FAST)) : $signed(CW'(1));
    case (step_dir)
      DIR_LEFT:  cand_s = pos_s - step_s;
      DIR_RIGHT: cand_s = pos_s + step_s;
      default:   cand_s = pos_s;
    endcase

    // Clamp every cycle so a width change that overhangs the right wall
    // pulls the paddle back in even without a step.
    clamp_s = cand_s;
    if (cand_s < $signed(CW'(0))) begin
      clamp_s = '0;
    end else if (cand_s > lim_s) begin
      clamp_s = lim_s;
    end

    pos_d   = PW'(clamp_s);
    moved_d = (pos_d != pos_q);
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_q      <= POS_RESET;
      prev_q     <= '0;
      primed_q   <= 1'b0;
      last_dir_q <= DIR_NONE;
      run_cnt_q  <= RUN_SAT;
      auto_cnt_q <= '0;
      moved_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      pos_q      <= pos_d;
      prev_q     <= encoder_value;
      primed_q   <= 1'b1;
      last_dir_q <= last_dir_d;
      run_cnt_q  <= run_cnt_d;
      auto_cnt_q <= auto_cnt_d;
      moved_q    <= moved_d;
    end
  end

  // Occupancy mask: columns pos .. pos+w-1.
  always_comb begin
    paddle_o = '0;
    for (int i = 0; i < FIELD_W; i++) begin
      paddle_o[i] = (i >= int'(pos_q)) && (i < int'(pos_q) + int'(w));
    end
  end

  assign pos_o  = pos_q;
  assign at_min = (pos_q == '0);
  assign at_max = (pos_s == lim_s);
  assign moved  = moved_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Testbench for paddle_ctrl: directed encoder/auto-mode vectors. Every move
// the stimulus expects is queued; a monitor pops one entry per moved strobe.
module tb_paddle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  width;
  logic [1:0]  encoder_value;
  logic        auto_mode;
  logic [3:0]  target_col;
  logic [15:0] paddle_o;
  logic [3:0]  pos_o;
  logic        at_min;
  logic        at_max;
  logic        moved;

  paddle_ctrl #(
    .FIELD_W     (16),
    .PW0         (8),
    .PW1         (6),
    .PW2         (4),
    .PW3         (3),
    .STEP_FAST   (2),
    .ACCEL_WINDOW(20),
    .AUTO_DIV    (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .width        (width),
    .encoder_value(encoder_value),
    .auto_mode    (auto_mode),
    .target_col   (target_col),
    .paddle_o     (paddle_o),
    .pos_o        (pos_o),
    .at_min       (at_min),
    .at_max       (at_max),
    .moved        (moved)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pos;
    logic [15:0] mask;
    logic        amin;
    logic        amax;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_move(input logic [3:0] p, input logic [15:0] m,
                             input logic amin, input logic amax);
    exp_t e;
    e.pos  = p;
    e.mask = m;
    e.amin = amin;
    e.amax = amax;
    exp_q.push_back(e);
  endtask

  // Advance n rising edges, then settle 2 time units past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: every moved strobe must match the next queued move.
  always @(negedge clk) begin
    if (reset && moved) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_move: pos_o=%0d paddle_o=0x%0h, no move queued (t=%0t)",
                 pos_o, paddle_o, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("move_pos",    pos_o,    mon_e.pos);
        check("move_mask",   paddle_o, mon_e.mask);
        check("move_at_min", at_min,   mon_e.amin);
        check("move_at_max", at_max,   mon_e.amax);
      end
    end
  end

  initial begin
    reset         = 1'b0;
    width         = 2'd0;
    encoder_value = 2'd1;
    auto_mode     = 1'b0;
    target_col    = 4'd0;
    #12;
    check("rst_pos",    pos_o,    4);
    check("rst_mask",   paddle_o, 16'h0FF0);
    check("rst_moved",  moved,    0);
    check("rst_at_min", at_min,   0);
    check("rst_at_max", at_max,   0);

    // Priming: a nonzero count at release must not move the paddle.
    @(posedge clk); #2;
    reset = 1'b1;
    tick(25);
    check("prime_pos", pos_o, 4);

    // Slow +1 steps toward column 0, then against the wall.
    encoder_value = 2'd2; expect_move(4'd3, 16'h07F8, 1'b0, 1'b0); tick(25);
    encoder_value = 2'd3; expect_move(4'd2, 16'h03FC, 1'b0, 1'b0); tick(25);
    encoder_value = 2'd0; expect_move(4'd1, 16'h01FE, 1'b0, 1'b0); tick(25);
    encoder_value = 2'd1; expect_move(4'd0, 16'h00FF, 1'b1, 1'b0); tick(25);
    encoder_value = 2'd2; tick(25);
    check("left_wall_pos",    pos_o,  0);
    check("left_wall_at_min", at_min, 1);

    // Async reset, then -1 steps 10 cycles apart with acceleration.
    reset         = 1'b0;
    encoder_value = 2'd0;
    #1;
    check("rst2_async_pos", pos_o, 4);
    tick(2);
    reset = 1'b1;
    tick(3);
    encoder_value = 2'd3; expect_move(4'd5, 16'h1FE0, 1'b0, 1'b0); tick(10);
    encoder_value = 2'd2; expect_move(4'd7, 16'h7F80, 1'b0, 1'b0); tick(10);
    encoder_value = 2'd1; expect_move(4'd8, 16'hFF00, 1'b0, 1'b1); tick(10);
    encoder_value = 2'd0; tick(10);
    check("right_wall_pos",    pos_o,  8);
    check("right_wall_at_max", at_max, 1);

    // Narrow paddle moves further right; widening clamps it back.
    width = 2'd3;
    encoder_value = 2'd3; expect_move(4'd10, 16'h1C00, 1'b0, 1'b0); tick(10);
    encoder_value = 2'd2; expect_move(4'd12, 16'h7000, 1'b0, 1'b0); tick(10);
    check("narrow_at_max", at_max, 0);
    width = 2'd0; expect_move(4'd8, 16'hFF00, 1'b0, 1'b1); tick(5);

    // Missed edge (2'b10) keeps run_cnt counting: next step is slow.
    encoder_value = 2'd3; expect_move(4'd7, 16'h7F80, 1'b0, 1'b0); tick(15);
    encoder_value = 2'd1; tick(10);
    check("missed_edge_pos", pos_o, 7);
    encoder_value = 2'd2; expect_move(4'd6, 16'h3FC0, 1'b0, 1'b0); tick(10);

    // Auto mode, width=2 (w=4), tracking target 12.
    reset      = 1'b0;
    width      = 2'd2;
    auto_mode  = 1'b1;
    target_col = 4'd12;
    #1;
    check("rst3_async_pos", pos_o, 4);
    tick(1);
    reset = 1'b1;
    tick(1);
    tick(3);
    check("auto_wait_pos", pos_o, 4);
    expect_move(4'd5,  16'h01E0, 1'b0, 1'b0);
    expect_move(4'd6,  16'h03C0, 1'b0, 1'b0);
    expect_move(4'd7,  16'h0780, 1'b0, 1'b0);
    expect_move(4'd8,  16'h0F00, 1'b0, 1'b0);
    expect_move(4'd9,  16'h1E00, 1'b0, 1'b0);
    expect_move(4'd10, 16'h3C00, 1'b0, 1'b0);
    tick(1);
    check("auto_first_pos", pos_o, 5);
    for (int i = 0; i < 40; i++) begin
      encoder_value = encoder_value + 2'd1;
      tick(1);
    end
    check("auto_settled_pos",  pos_o,    10);
    check("auto_settled_mask", paddle_o, 16'h3C00);

    // Retarget left, then assert reset in the middle of the run.
    auto_mode = 1'b0;
    tick(2);
    target_col = 4'd2;
    auto_mode  = 1'b1;
    expect_move(4'd9, 16'h1E00, 1'b0, 1'b0);
    expect_move(4'd8, 16'h0F00, 1'b0, 1'b0);
    tick(9);
    reset = 1'b0;
    #1;
    check("auto_rst_pos",   pos_o,    4);
    check("auto_rst_mask",  paddle_o, 16'h00F0);
    check("auto_rst_moved", moved,    0);
    auto_mode = 1'b0;
    width     = 2'd0;
    tick(1);
    reset = 1'b1;
    tick(5);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
